// File: rtl/exec_ctrl_pkg.sv
// Shared types and default constants for the execute-stage sequencer.
package exec_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, MULDIV, OUT} state_e;

  localparam int XLEN_DEF       = 64;
  localparam int MD_TIMEOUT_DEF = 80;
  localparam int CNT_W_DEF      = 8;
endpackage

// File: rtl/md_watchdog.sv
// Mul/div cycle counter with saturation and a sticky timeout error.
module md_watchdog #(
  parameter int MD_TIMEOUT = 80,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout,
  output logic error
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MD_TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Fires on the cycle whose increment brings the count to the limit,
  // so a mul/div gets exactly MD_TIMEOUT cycles before being cut off.
  assign timeout = enable && (cnt == LIMIT - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      if (clear)
        cnt <= '0;
      else if (enable && cnt != LIMIT)
        cnt <= cnt + 1'b1;
      if (timeout)
        error <= 1'b1;
    end
  end
endmodule

// File: rtl/execute_sequencer.sv
// Execute-stage control: decode handshake, executor enable, mul/div
// sequencing, jump redirect/flush and result hold toward memory.
module execute_sequencer
  import exec_ctrl_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic            id_is_muldiv,
  output logic            exe_enable,
  input  logic            exe_done,
  input  logic            exe_jump_taken,
  input  logic [XLEN-1:0] exe_target,
  output logic            md_start,
  input  logic            md_done,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_upstream,
  output logic            md_error,
  output logic            busy
);
  state_e state, state_nxt;
  logic   jump_q, md_first, md_clear, md_en, md_timeout, redirect;

  // jump_q is only set by an EXEC latch and cleared in the first OUT cycle,
  // so this is a single-cycle pulse per taken jump.
  assign redirect       = (state == OUT) && jump_q;
  assign redirect_valid = redirect;
  assign flush_upstream = redirect;
  assign busy           = (state != IDLE);
  assign md_en          = (state == MULDIV) && !md_done;

  md_watchdog #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (md_clear),
    .enable (md_en),
    .timeout(md_timeout),
    .error  (md_error)
  );

  always_comb begin
    state_nxt  = state;
    id_ready   = 1'b0;
    exe_enable = 1'b0;
    md_start   = 1'b0;
    ex_valid   = 1'b0;
    case (state)
      IDLE: begin
        id_ready = 1'b1;
        if (id_valid) state_nxt = id_is_muldiv ? MULDIV : EXEC;
      end
      EXEC: begin
        exe_enable = 1'b1;
        if (exe_done) state_nxt = OUT;
      end
      MULDIV: begin
        md_start = md_first;
        if (md_done || md_timeout) state_nxt = OUT;
      end
      OUT: begin
        ex_valid = 1'b1;
        if (ex_ready) begin
          if (id_valid && !redirect) begin
            id_ready  = 1'b1;
            state_nxt = id_is_muldiv ? MULDIV : EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    md_clear = (state != MULDIV) && (state_nxt == MULDIV);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      jump_q      <= 1'b0;
      md_first    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state    <= state_nxt;
      md_first <= md_clear;
      if (state == EXEC && exe_done) begin
        jump_q      <= exe_jump_taken;
        redirect_pc <= exe_target;
      end else if (redirect || state == MULDIV) begin
        jump_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_execute_sequencer.sv
// Directed bench for execute_sequencer: driver queues expected results,
// a negedge monitor checks every result handshake and redirect pulse.
module tb_execute_sequencer;
  localparam int XLEN = 64;
  localparam int MDT  = 80;

  logic            clk = 1'b0, reset;
  logic            id_valid, id_ready, id_is_muldiv;
  logic            exe_enable, exe_done, exe_jump_taken;
  logic [XLEN-1:0] exe_target, redirect_pc;
  logic            md_start, md_done, ex_valid, ex_ready;
  logic            redirect_valid, flush_upstream, md_error, busy;

  execute_sequencer #(.XLEN(XLEN), .MD_TIMEOUT(MDT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready), .id_is_muldiv(id_is_muldiv),
    .exe_enable(exe_enable), .exe_done(exe_done), .exe_jump_taken(exe_jump_taken),
    .exe_target(exe_target), .md_start(md_start), .md_done(md_done),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_upstream(flush_upstream),
    .md_error(md_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic        err;
  } res_t;

  res_t        sb_q[$];
  logic [63:0] rd_q[$];
  int          checks = 0, errors = 0;
  logic [63:0] exp_pc = '0;
  int          n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    chk({name, "_flags"},
        {56'd0, id_ready, exe_enable, md_start, ex_valid, redirect_valid, flush_upstream, md_error, busy},
        64'h80);
    chk({name, "_redirect_pc"}, redirect_pc, 64'h0);
  endtask

  task automatic push_res(input logic [63:0] pc, input logic err);
    res_t r;
    r.pc  = pc;
    r.err = err;
    sb_q.push_back(r);
  endtask

  // Monitor: pops one expectation per accepted result and per redirect.
  always @(negedge clk) begin : mon
    res_t        e;
    logic [63:0] rp;
    if (!reset) begin
      if (ex_valid && ex_ready) begin
        if (sb_q.size() == 0) chk("unexpected_result", 64'(sb_q.size()), 64'd1);
        else begin
          e = sb_q.pop_front();
          chk("result_pc", redirect_pc, e.pc);
          chk("result_md_error", {63'd0, md_error}, {63'd0, e.err});
        end
      end
      if (redirect_valid) begin
        if (rd_q.size() == 0) chk("unexpected_redirect", 64'(rd_q.size()), 64'd1);
        else begin
          rp = rd_q.pop_front();
          chk("redirect_pc", redirect_pc, rp);
          chk("flush_with_redirect", {63'd0, flush_upstream}, 64'd1);
          chk("id_ready_in_redirect", {63'd0, id_ready}, 64'd0);
        end
      end else begin
        chk("flush_without_redirect", {63'd0, flush_upstream}, 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_is_muldiv = 1'b0; exe_done = 1'b1;
    exe_jump_taken = 1'b0; exe_target = '0; md_done = 1'b0; ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk); check_idle("reset_state");
    tick(); reset = 1'b0;
    @(negedge clk); check_idle("after_reset");

    // Simple op, then hold the result for 3 cycles with memory stalled
    tick(); id_valid = 1'b1; id_is_muldiv = 1'b0; exe_target = 64'h55; ex_ready = 1'b0;
    push_res(64'h55, 1'b0); exp_pc = 64'h55;
    @(negedge clk); chk("simple_accept", {63'd0, id_ready}, 64'd1);
    tick(); id_valid = 1'b0;
    @(negedge clk); chk("simple_exe_enable", {63'd0, exe_enable}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); id_valid = 1'b1; exe_target = 64'h99;
      @(negedge clk);
      chk("hold_ex_valid", {63'd0, ex_valid}, 64'd1);
      chk("hold_no_accept", {63'd0, id_ready}, 64'd0);
      chk("hold_exe_enable_low", {63'd0, exe_enable}, 64'd0);
      chk("hold_pc", redirect_pc, 64'h55);
    end
    tick(); id_valid = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk); chk("simple_back_idle", {63'd0, busy}, 64'd0);

    // Taken jump: redirect in first OUT cycle, nothing accepted there
    tick(); id_valid = 1'b1; exe_jump_taken = 1'b1; exe_target = 64'h1000;
    push_res(64'h1000, 1'b0); rd_q.push_back(64'h1000); exp_pc = 64'h1000;
    tick();
    @(negedge clk); chk("jump_exe_enable", {63'd0, exe_enable}, 64'd1);
    tick(); exe_jump_taken = 1'b0; exe_target = 64'hdead;
    @(negedge clk); chk("jump_redirect", {63'd0, redirect_valid}, 64'd1);
    tick(); id_valid = 1'b0;
    @(negedge clk);
    chk("jump_no_accept", {63'd0, busy}, 64'd0);
    chk("jump_single_pulse", {63'd0, redirect_valid}, 64'd0);

    // Mul/div finishing in its 5th cycle
    tick(); id_valid = 1'b1; id_is_muldiv = 1'b1;
    push_res(exp_pc, 1'b0);
    @(negedge clk); chk("md_accept", {63'd0, id_ready}, 64'd1);
    for (int i = 1; i <= 5; i++) begin
      tick(); id_valid = 1'b0; md_done = (i == 5);
      @(negedge clk);
      chk("md_start_pulse", {63'd0, md_start}, (i == 1) ? 64'd1 : 64'd0);
      chk("md_no_early_valid", {63'd0, ex_valid}, 64'd0);
    end
    tick(); md_done = 1'b0;
    @(negedge clk);
    chk("md_result_latency", {63'd0, ex_valid}, 64'd1);
    chk("md_no_error", {63'd0, md_error}, 64'd0);

    // md_done in the final allowed cycle counts as done
    tick(); id_valid = 1'b1;
    push_res(exp_pc, 1'b0);
    for (int i = 1; i <= MDT; i++) begin
      tick(); id_valid = 1'b0; md_done = (i == MDT);
      if (i == MDT) begin
        @(negedge clk); chk("boundary_still_muldiv", {63'd0, ex_valid}, 64'd0);
      end
    end
    tick(); md_done = 1'b0;
    @(negedge clk);
    chk("boundary_valid", {63'd0, ex_valid}, 64'd1);
    chk("boundary_no_error", {63'd0, md_error}, 64'd0);

    // Four back-to-back simple ops
    tick(); id_valid = 1'b1; id_is_muldiv = 1'b0; exe_target = 64'h40;
    for (int k = 0; k < 4; k++) push_res(64'h40, 1'b0);
    exp_pc = 64'h40;
    for (int i = 0; i < 8; i++) begin
      tick(); if (i == 6) id_valid = 1'b0;
      @(negedge clk);
      chk("tput_ex_valid", {63'd0, ex_valid}, 64'(i % 2));
      chk("tput_busy", {63'd0, busy}, 64'd1);
    end
    tick();
    @(negedge clk); chk("tput_idle_after", {63'd0, busy}, 64'd0);

    // Reset three cycles after md_start; later md_done must be ignored
    tick(); id_valid = 1'b1; id_is_muldiv = 1'b1;
    tick(); id_valid = 1'b0;
    @(negedge clk); chk("rst_md_start", {63'd0, md_start}, 64'd1);
    repeat (3) tick();
    reset = 1'b1;
    @(negedge clk); check_idle("reset_mid_muldiv");
    tick(); reset = 1'b0; md_done = 1'b1; exp_pc = 64'h0;
    @(negedge clk); chk("stray_md_done_idle", {63'd0, busy}, 64'd0);
    tick(); md_done = 1'b0;
    @(negedge clk); chk("stray_md_done_no_valid", {63'd0, ex_valid}, 64'd0);

    // Timeout: md_done never comes
    tick(); id_valid = 1'b1; id_is_muldiv = 1'b1;
    push_res(exp_pc, 1'b1);
    tick(); id_valid = 1'b0; n = 1;
    @(negedge clk);
    while (!ex_valid && n < 200) begin
      tick(); n++;
      @(negedge clk);
    end
    chk("timeout_cycles", 64'(n), 64'(MDT + 1));
    chk("timeout_error", {63'd0, md_error}, 64'd1);

    // Error stays set across a following instruction
    tick(); id_valid = 1'b1; id_is_muldiv = 1'b0; exe_target = 64'h77;
    push_res(64'h77, 1'b1); exp_pc = 64'h77;
    tick(); id_valid = 1'b0;
    tick();
    @(negedge clk); chk("error_sticky", {63'd0, md_error}, 64'd1);
    tick();
    reset = 1'b1;
    @(negedge clk); check_idle("final_reset");
    tick(); reset = 1'b0;
    repeat (2) tick();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    chk("redirects_drained", 64'(rd_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
